mem_port_arbiter: RTL

Arbiter and sequencer for the single-ported unified instruction/data memory of the pipelined MIPS core. It shares one memory port between the IF-stage fetch requester and the MEM-stage load/store requester, drives a variable-latency memory handshake, and returns per-requester acknowledges and stall flags. The hazard unit consumes these flags to freeze PC, IF/ID and the downstream pipeline registers.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: IF fetch port, MEM load/store port and
// the single downstream memory handshake.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic                  if_stall;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ack;
  logic                  dm_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_ack, if_stall,
    output dm_rdata, dm_ack, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_stall,
    input  dm_rdata, dm_ack, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF fetch and MEM load/store.
// ARB_RR_EN: alternate grants under contention instead of dm-first.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY
  } state_t;

  state_t state;
  state_t stateNext;

  logic                  ifElig;
  logic                  dmElig;
  logic                  pickDm;
  logic                  grantIf;
  logic                  grantDm;
  logic                  ifDone;
  logic                  dmDone;

  logic                  ifAck;
  logic                  dmAck;
  logic [DATA_WIDTH-1:0] ifRdata;
  logic [DATA_WIDTH-1:0] dmRdata;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;

`ifdef ARB_RR_EN
  logic                  lastGrantDm;
`endif

  // A requester whose ack is high is retiring; its req is stale.
  assign ifElig = bus.if_req & ~ifAck;
  assign dmElig = bus.dm_req & ~dmAck;

`ifdef ARB_RR_EN
  assign pickDm = dmElig & (~ifElig | ~lastGrantDm);
`else
  assign pickDm = dmElig;
`endif

  always_comb begin
    stateNext = state;
    grantIf   = 1'b0;
    grantDm   = 1'b0;
    ifDone    = 1'b0;
    dmDone    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pickDm) begin
          grantDm   = 1'b1;
          stateNext = DM_BUSY;
        end else if (ifElig) begin
          grantIf   = 1'b1;
          stateNext = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (bus.mem_ready) begin
          ifDone    = 1'b1;
          stateNext = IDLE;
        end
      end
      DM_BUSY: begin
        if (bus.mem_ready) begin
          dmDone    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ifAck <= 1'b0;
      dmAck <= 1'b0;
    end else begin
      state <= stateNext;
      ifAck <= ifDone;
      dmAck <= dmDone;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
    end else if (grantDm) begin
      memWe    <= bus.dm_we;
      memAddr  <= bus.dm_addr;
      memWdata <= bus.dm_wdata;
    end else if (grantIf) begin
      memWe    <= 1'b0;
      memAddr  <= bus.if_addr;
      memWdata <= '0;
    end
  end

  // Stores complete without touching the load-data register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ifRdata <= '0;
      dmRdata <= '0;
    end else begin
      if (ifDone)
        ifRdata <= bus.mem_rdata;
      if (dmDone && !memWe)
        dmRdata <= bus.mem_rdata;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!reset)
      lastGrantDm <= 1'b0;
    else if (grantDm)
      lastGrantDm <= 1'b1;
    else if (grantIf)
      lastGrantDm <= 1'b0;
  end
`endif

  assign bus.mem_req   = (state != IDLE);
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;

  assign bus.if_ack    = ifAck;
  assign bus.if_rdata  = ifRdata;
  assign bus.if_stall  = bus.if_req & ~ifAck;

  assign bus.dm_ack    = dmAck;
  assign bus.dm_rdata  = dmRdata;
  assign bus.dm_stall  = bus.dm_req & ~dmAck;

endmodule
